// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Holds the FSM encoding and the bundle of strobes sent to the pipe registers.
package pipeline_stall_ctrl_pkg;

    localparam int MD_CYCLES_DEF = 32;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        MDBUSY = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic nop;
        logic ex_bubble;
        logic flush;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = '0;

    localparam ctrl_t CTRL_BOOT = '{
        pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b1, exmem_we: 1'b1,
        nop: 1'b1, ex_bubble: 1'b1, flush: 1'b1
    };

    localparam ctrl_t CTRL_STALL = '{
        pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b1, exmem_we: 1'b1,
        nop: 1'b1, ex_bubble: 1'b0, flush: 1'b0
    };

    localparam ctrl_t CTRL_GO = '{
        pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1, exmem_we: 1'b1,
        nop: 1'b0, ex_bubble: 1'b0, flush: 1'b0
    };

    localparam ctrl_t CTRL_MDHOLD = '{
        pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0, exmem_we: 1'b1,
        nop: 1'b0, ex_bubble: 1'b1, flush: 1'b0
    };

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Request/strobe bundle between hazard unit, ID stage and the sequencer.
// master drives the requests, slave (the sequencer) drives the strobes.
interface pipeline_stall_ctrl_if
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             hzStall_in;
    logic             hzFlush_in;
    logic             mdStart_in;
    logic             dmemWait_in;
    logic             stallClr_in;
    logic             PCWrite_out;
    logic             IFIDWrite_out;
    logic             IDEXWrite_out;
    logic             EXMEMWrite_out;
    logic             NOP_out;
    logic             exBubble_out;
    logic             FLUSH_out;
    logic             mdBusy_out;
    logic [CNT_W-1:0] stallCnt_out;

    modport master (
        output hzStall_in, hzFlush_in, mdStart_in,
        output dmemWait_in, stallClr_in,
        input  PCWrite_out, IFIDWrite_out, IDEXWrite_out,
        input  EXMEMWrite_out, NOP_out, exBubble_out,
        input  FLUSH_out, mdBusy_out, stallCnt_out
    );

    modport slave (
        input  hzStall_in, hzFlush_in, mdStart_in,
        input  dmemWait_in, stallClr_in,
        output PCWrite_out, IFIDWrite_out, IDEXWrite_out,
        output EXMEMWrite_out, NOP_out, exBubble_out,
        output FLUSH_out, mdBusy_out, stallCnt_out
    );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Merges hazard stall/flush, mult/div occupancy and dmem wait into
// pipeline register enables, bubble and flush strobes.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input logic                   clk_in,
    input logic                   reset_in,
    pipeline_stall_ctrl_if.slave  bus
);

    localparam int MDW = $clog2(MD_CYCLES);
    localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_CYCLES - 2);

    state_e         state_q;
    state_e         state_d;
    logic [MDW-1:0] md_cnt_q;
    logic [MDW-1:0] md_cnt_d;
    ctrl_t          ctrl;
    logic           md_last;
    logic           stall_inc;

    assign md_last = (md_cnt_q == '0);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= BOOT;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!bus.dmemWait_in && !bus.hzStall_in &&
                    bus.mdStart_in) begin
                    state_d  = MDBUSY;
                    md_cnt_d = MD_LOAD;
                end
            end
            MDBUSY: begin
                if (!md_last) begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
                if (md_last && !bus.dmemWait_in) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // A dmem freeze overrides everything outside BOOT, including mult/div.
    always_comb begin
        ctrl = CTRL_FREEZE;
        unique case (state_q)
            BOOT: begin
                ctrl = CTRL_BOOT;
            end
            RUN: begin
                if (bus.dmemWait_in) begin
                    ctrl = CTRL_FREEZE;
                end else if (bus.hzStall_in) begin
                    ctrl = CTRL_STALL;
                end else begin
                    ctrl       = CTRL_GO;
                    ctrl.flush = bus.hzFlush_in;
                end
            end
            MDBUSY: begin
                if (bus.dmemWait_in) begin
                    ctrl = CTRL_FREEZE;
                end else if (md_last) begin
                    ctrl = CTRL_GO;
                end else begin
                    ctrl = CTRL_MDHOLD;
                end
            end
            default: begin
                ctrl = CTRL_FREEZE;
            end
        endcase
    end

    assign bus.PCWrite_out    = ctrl.pc_we;
    assign bus.IFIDWrite_out  = ctrl.ifid_we;
    assign bus.IDEXWrite_out  = ctrl.idex_we;
    assign bus.EXMEMWrite_out = ctrl.exmem_we;
    assign bus.NOP_out        = ctrl.nop;
    assign bus.exBubble_out   = ctrl.ex_bubble;
    assign bus.FLUSH_out      = ctrl.flush;
    assign bus.mdBusy_out     = (state_q == MDBUSY);

    assign stall_inc = (state_q != BOOT) && !ctrl.pc_we;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .inc      (stall_inc),
        .clr      (bus.stallClr_in),
        .count    (bus.stallCnt_out)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed plus random stimulus for pipeline_stall_ctrl, checked cycle by
// cycle against a cycle-count reference model of the sequencing rules.
module tb_pipeline_stall_ctrl;

    localparam int MD   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_stall_ctrl #(
        .MD_CYCLES (MD),
        .CNT_W     (CW)
    ) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // model: boot flag, mult/div cycles left in EX after issue, stall count
    bit m_boot    = 1'b1;
    int m_md_left = 0;
    int m_cnt     = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {pc, ifid, idex, exmem, nop, exbubble, flush, busy}
    function automatic logic [7:0] model_ctrl(input bit hs, input bit hf,
                                              input bit dw);
        if (rst || m_boot) return 8'b0011111_0;
        if (m_md_left > 0) begin
            if (dw) return 8'b0000000_1;
            if (m_md_left == 1) return 8'b1111000_1;
            return 8'b0001010_1;
        end
        if (dw) return 8'b0000000_0;
        if (hs) return 8'b0011100_0;
        return {6'b111100, hf, 1'b0};
    endfunction

    task automatic model_advance(input bit hs, input bit ms, input bit dw,
                                 input bit cl, input bit pc);
        bit was_boot;
        was_boot = m_boot;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_md_left > 0) begin
            if (m_md_left == 1) begin
                if (!dw) m_md_left = 0;
            end else begin
                m_md_left--;
            end
        end else if (!dw && !hs && ms) begin
            m_md_left = MD - 1;
        end
        if (cl) m_cnt = 0;
        else if (!was_boot && !pc && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic step(input bit hs, input bit hf, input bit ms,
                        input bit dw, input bit cl, input string tag);
        logic [7:0] e;
        logic [7:0] o;
        @(negedge clk);
        bus.hzStall_in  = hs;
        bus.hzFlush_in  = hf;
        bus.mdStart_in  = ms;
        bus.dmemWait_in = dw;
        bus.stallClr_in = cl;
        #1;
        e = model_ctrl(hs, hf, dw);
        o = {bus.PCWrite_out, bus.IFIDWrite_out, bus.IDEXWrite_out,
             bus.EXMEMWrite_out, bus.NOP_out, bus.exBubble_out,
             bus.FLUSH_out, bus.mdBusy_out};
        check({tag, ":ctl"}, 32'(o), 32'(e));
        check({tag, ":cnt"}, 32'(bus.stallCnt_out), 32'(m_cnt));
        if (!rst) model_advance(hs, ms, dw, cl, e[7]);
    endtask

    task automatic assert_reset_mid_cycle();
        @(posedge clk);
        #2;
        rst       = 1'b1;
        m_boot    = 1'b1;
        m_md_left = 0;
        m_cnt     = 0;
        #1;
        check("rst_async_busy", 32'(bus.mdBusy_out), 32'd0);
        check("rst_async_cnt", 32'(bus.stallCnt_out), 32'(m_cnt));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.hzStall_in  = 1'b0;
        bus.hzFlush_in  = 1'b0;
        bus.mdStart_in  = 1'b0;
        bus.dmemWait_in = 1'b0;
        bus.stallClr_in = 1'b0;

        step(1, 1, 1, 1, 0, "rst_hold0");
        step(0, 0, 0, 0, 0, "rst_hold1");
        release_reset();
        step(1, 0, 1, 0, 0, "boot");
        step(0, 0, 0, 0, 0, "run_idle");

        step(1, 0, 0, 0, 0, "hz_stall");
        step(0, 0, 0, 0, 0, "after_stall");
        step(0, 1, 0, 0, 0, "flush");
        step(1, 1, 0, 0, 0, "stall_flush");

        step(0, 0, 1, 0, 0, "md_issue");
        step(1, 1, 1, 0, 0, "md_busy0");
        step(0, 0, 0, 0, 0, "md_busy1");
        step(0, 0, 0, 0, 0, "md_done");
        step(0, 0, 0, 0, 0, "md_after");

        step(0, 0, 1, 0, 0, "md2_issue");
        step(0, 0, 0, 0, 0, "md2_busy0");
        step(0, 0, 0, 1, 0, "md2_wait0");
        step(0, 0, 0, 1, 0, "md2_wait1");
        step(0, 0, 0, 0, 0, "md2_done");
        step(0, 0, 0, 0, 0, "md2_after");

        step(0, 1, 1, 0, 0, "flush_md");
        step(0, 0, 0, 0, 0, "flush_md_busy");
        assert_reset_mid_cycle();
        step(0, 0, 0, 0, 0, "rst_in_md");
        release_reset();
        step(0, 0, 0, 0, 0, "boot2");
        step(0, 0, 0, 0, 0, "run2");

        step(0, 0, 1, 1, 0, "md_vs_wait");
        step(0, 0, 0, 0, 0, "md_not_started");

        repeat (CMAX + 3) step(1, 0, 0, 0, 0, "sat");
        step(1, 0, 0, 0, 1, "clr_stall");
        step(0, 0, 0, 0, 0, "after_clr");

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 19) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
